pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Central stall controller for the 5-stage MIPS pipeline (PC/IF/ID/EX/MEM/WB).
//  Merges stall requests from IF (inst SRAM wait), ID (load-use), EX (multi-cycle
//  mul/div) and MEM (data SRAM wait) into the 6-bit stall bus. Sequences the
//  multi-cycle MDU with a cycle counter. Tells ID when to replay its latched instruction.
// PARAMETERS
//  DIV_CYCLES  33  total EX stall cycles for a divide (>=2)
//  MUL_CYCLES  2   total EX stall cycles for a multiply (>=2)
//  CNT_W       6   counter width; must hold max(DIV_CYCLES,MUL_CYCLES)-1
// PORTS
//  clk            in   1  clock
//  rst            in   1  synchronous active-high reset
//  if_inst_wait   in   1  inst SRAM not ready this cycle
//  id_stallreq    in   1  load-use hazard detected in ID (level)
//  ex_mdu_req     in   1  EX holds a mul/div instruction (level, held while in EX)
//  ex_mdu_is_div  in   1  1=divide, 0=multiply; sampled with ex_mdu_req in IDLE
//  mem_data_wait  in   1  data SRAM not ready this cycle
//  stall          out  6  {WB,MEM,EX,ID,IF,PC}; 1=Stop, 0=NoStop
//  mdu_busy       out  1  MDU FSM in BUSY
//  mdu_done       out  1  one-cycle pulse: MDU result valid in EX this cycle
//  id_inst_hold   out  1  ID must use its latched instruction instead of inst_sram_rdata
// BEHAVIOUR
//  Reset (rst=1 at posedge): FSM->IDLE, cnt=0, hold flag=0; stall=6'b0, mdu_busy=0,
//   mdu_done=0, id_inst_hold=0. rst mid-MDU aborts the operation; no mdu_done pulse.
//  Stall encoding (combinational, OR of all active masks; deepest mask wins):
//   mem_data_wait          -> 6'b011111
//   MDU stall (below)      -> 6'b001111
//   id_stallreq            -> 6'b000111 (bubble enters EX: stall[2]=1, stall[3]=0)
//   if_inst_wait           -> 6'b000011 (bubble enters ID)
//   none                   -> 6'b000000; stall[5] is always 0.
//  MDU FSM (states IDLE, BUSY, DONE):
//   IDLE: ex_mdu_req=1 -> MDU stall asserted this same cycle; cnt<=N-1
//     (N=DIV_CYCLES if ex_mdu_is_div else MUL_CYCLES); ->BUSY.
//   BUSY: MDU stall asserted; mdu_busy=1; cnt<=cnt-1; when cnt==1 -> DONE.
//     Total MDU-induced stall = N cycles (IDLE-req cycle + N-1 BUSY cycles).
//     ex_mdu_is_div changes ignored while BUSY.
//   DONE: no MDU stall; mdu_done=1. If stall[3]==1 (mem_data_wait) stay DONE with
//     mdu_done held 1; else ->IDLE. ex_mdu_req is ignored in DONE (same instruction
//     still in EX; must not restart).
//   Back-to-back: a new ex_mdu_req seen in IDLE the cycle after DONE starts a new op.
//  Instruction hold (compensates sync inst SRAM losing data while ID stalls):
//   hold_r <= (stall[2]==1 && stall[3]==0 ? 1 : stall[2]) each cycle, i.e. set on
//   any cycle with stall[2]=1, cleared on the first cycle with stall[2]=0.
//   id_inst_hold = hold_r (registered, one-cycle lag); ID latches rdata on the first
//   cycle stall[2] rises and replays it while id_inst_hold=1.
//  Simultaneous events: masks OR together; e.g. mem_data_wait during BUSY still
//   counts cnt down (MDU runs independently of MEM stall).
//  No combinational path from stall back into any request input.
// TESTING
//  1 rst 3 cycles -> stall=0, mdu_busy=0, mdu_done=0, id_inst_hold=0.
//  2 id_stallreq=1 for 1 cycle -> stall=000111 that cycle, then 000000;
//    id_inst_hold=1 exactly the following cycle.
//  3 ex_mdu_req=1, is_div=1 held -> stall=001111 for 33 cycles, mdu_busy=1 for 32,
//    mdu_done=1 on cycle 34 with stall=000000; ex_mdu_req still 1 -> no restart.
//  4 multiply (MUL_CYCLES=2) with mem_data_wait=1 on DONE cycle -> stall=011111,
//    mdu_done stays 1 until wait drops, then FSM IDLE.
//  5 rst asserted at BUSY cnt=10 -> next cycle IDLE, stall=0, no mdu_done pulse.
//  6 if_inst_wait + id_stallreq same cycle -> stall=000111; with mem_data_wait too -> 011111.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline stall controller: merges per-stage stall requests into the
// {WB,MEM,EX,ID,IF,PC} stall bus and sequences the multi-cycle mul/div unit.
module pipeline_stall_ctrl #(
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_inst_wait,
  input  logic       id_stallreq,
  input  logic       ex_mdu_req,
  input  logic       ex_mdu_is_div,
  input  logic       mem_data_wait,
  output logic [5:0] stall,
  output logic       mdu_busy,
  output logic       mdu_done,
  output logic       id_inst_hold
);

  localparam int unsigned STALL_W = 6;

  // Each mask freezes its own stage and everything upstream of it.
  localparam logic [STALL_W-1:0] MASK_MEM = 6'b011111;
  localparam logic [STALL_W-1:0] MASK_MDU = 6'b001111;
  localparam logic [STALL_W-1:0] MASK_ID  = 6'b000111;
  localparam logic [STALL_W-1:0] MASK_IF  = 6'b000011;

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mdu_state_t;

  mdu_state_t       state;
  mdu_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             mdu_stall;
  logic             hold_r;

  // MDU state and countdown register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // MDU next-state, counter and stall request
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mdu_stall  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (ex_mdu_req) begin
          mdu_stall  = 1'b1;
          cnt_next   = ex_mdu_is_div ? DIV_LOAD : MUL_LOAD;
          state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        mdu_stall = 1'b1;
        cnt_next  = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        // Only a MEM wait can freeze EX here, so stall[3] reduces to mem_data_wait;
        // keeps the result presented until EX is allowed to advance.
        if (!mem_data_wait) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Stall bus: OR of all active masks, forced quiet while in reset
  always_comb begin
    stall = '0;
    if (!rst) begin
      if (mem_data_wait) stall = stall | MASK_MEM;
      if (mdu_stall)     stall = stall | MASK_MDU;
      if (id_stallreq)   stall = stall | MASK_ID;
      if (if_inst_wait)  stall = stall | MASK_IF;
    end
  end

  // Replay flag: set while ID is frozen, released the cycle after it unfreezes
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r <= 1'b0;
    end else begin
      hold_r <= stall[2];
    end
  end

  assign mdu_busy     = (state == S_BUSY);
  assign mdu_done     = (state == S_DONE);
  assign id_inst_hold = hold_r;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed scoreboard bench for pipeline_stall_ctrl: each step pushes the
// expected outputs for that cycle and pops/compares them mid-cycle.
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_inst_wait;
  logic       id_stallreq;
  logic       ex_mdu_req;
  logic       ex_mdu_is_div;
  logic       mem_data_wait;
  logic [5:0] stall;
  logic       mdu_busy;
  logic       mdu_done;
  logic       id_inst_hold;

  typedef struct packed {
    logic [5:0] stall;
    logic       busy;
    logic       done;
    logic       hold;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  pipeline_stall_ctrl #(
    .DIV_CYCLES(33),
    .MUL_CYCLES(2),
    .CNT_W     (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_inst_wait (if_inst_wait),
    .id_stallreq  (id_stallreq),
    .ex_mdu_req   (ex_mdu_req),
    .ex_mdu_is_div(ex_mdu_is_div),
    .mem_data_wait(mem_data_wait),
    .stall        (stall),
    .mdu_busy     (mdu_busy),
    .mdu_done     (mdu_done),
    .id_inst_hold (id_inst_hold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare at the falling edge.
  task automatic step(input string tag, input logic r, input logic iw, input logic idr,
                      input logic mr, input logic dv, input logic mw,
                      input logic [5:0] es, input logic eb, input logic ed, input logic eh);
    exp_t e;
    rst           = r;
    if_inst_wait  = iw;
    id_stallreq   = idr;
    ex_mdu_req    = mr;
    ex_mdu_is_div = dv;
    mem_data_wait = mw;
    sb.push_back('{stall: es, busy: eb, done: ed, hold: eh});
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, ".stall"}, 8'(stall), 8'(e.stall));
    chk({tag, ".busy"},  8'(mdu_busy), 8'(e.busy));
    chk({tag, ".done"},  8'(mdu_done), 8'(e.done));
    chk({tag, ".hold"},  8'(id_inst_hold), 8'(e.hold));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_inst_wait = 1'b0; id_stallreq = 1'b0;
    ex_mdu_req = 1'b0; ex_mdu_is_div = 1'b0; mem_data_wait = 1'b0;
    @(posedge clk);
    #1;

    //    tag           rst iw id mr dv mw  stall      busy done hold
    for (int i = 0; i < 3; i++)
      step("reset",      1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
    step("idle",         0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);

    // Load-use bubble and one-cycle replay
    step("lu_stall",     0, 0, 1, 0, 0, 0, 6'b000111, 0, 0, 0);
    step("lu_after",     0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1);
    step("lu_clear",     0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);

    // Inst wait alone does not freeze ID, so no replay
    step("if_wait",      0, 1, 0, 0, 0, 0, 6'b000011, 0, 0, 0);
    step("if_after",     0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);

    // Divide: 33 stall cycles, 32 busy, then done with req still held
    step("div_start",    0, 0, 0, 1, 1, 0, 6'b001111, 0, 0, 0);
    for (int i = 0; i < 32; i++)
      step("div_busy",   0, 0, 0, 1, i[0], 0, 6'b001111, 1, 0, 1);
    step("div_done",     0, 0, 0, 1, 1, 0, 6'b000000, 0, 1, 1);
    step("div_idle",     0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);

    // Multiply with MEM wait over the done cycle
    step("mul_start",    0, 0, 0, 1, 0, 0, 6'b001111, 0, 0, 0);
    step("mul_busy",     0, 0, 0, 1, 1, 0, 6'b001111, 1, 0, 1);
    step("mul_done_mw",  0, 0, 0, 1, 0, 1, 6'b011111, 0, 1, 1);
    step("mul_done_mw2", 0, 0, 0, 1, 0, 1, 6'b011111, 0, 1, 1);
    step("mul_done",     0, 0, 0, 1, 0, 0, 6'b000000, 0, 1, 1);
    step("mul_idle",     0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);

    // Back-to-back multiplies: new op starts in IDLE right after DONE
    step("b2b_start",    0, 0, 0, 1, 0, 0, 6'b001111, 0, 0, 0);
    step("b2b_busy",     0, 0, 0, 1, 0, 0, 6'b001111, 1, 0, 1);
    step("b2b_done",     0, 0, 0, 1, 0, 0, 6'b000000, 0, 1, 1);
    step("b2b_start2",   0, 0, 0, 1, 0, 0, 6'b001111, 0, 0, 0);
    step("b2b_busy2",    0, 0, 0, 1, 0, 0, 6'b001111, 1, 0, 1);
    step("b2b_done2",    0, 0, 0, 1, 0, 0, 6'b000000, 0, 1, 1);
    step("b2b_idle",     0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);

    // Divide aborted by reset at cnt=10 (BUSY cycles with cnt 32..11 first)
    step("abort_start",  0, 0, 0, 1, 1, 0, 6'b001111, 0, 0, 0);
    for (int i = 0; i < 22; i++)
      step("abort_busy", 0, 0, 0, 1, 1, 0, 6'b001111, 1, 0, 1);
    step("abort_rst",    1, 0, 0, 0, 0, 0, 6'b000000, 1, 0, 1);
    for (int i = 0; i < 3; i++)
      step("abort_idle", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);

    // Simultaneous requests
    step("if_id",        0, 1, 1, 0, 0, 0, 6'b000111, 0, 0, 0);
    step("if_id_mem",    0, 1, 1, 0, 0, 1, 6'b011111, 0, 0, 1);
    step("sim_after",    0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1);
    step("sim_clear",    0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
    step("mem_only",     0, 0, 0, 0, 0, 1, 6'b011111, 0, 0, 0);
    step("mem_after",    0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1);

    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
